taillights_input_cond: RTL

//  Front end of the taillights controller. Synchronizes and debounces the raw left/right/hazard

---
 rtl/taillights_pkg.sv | 21 ++
 rtl/taillights_input_cond_if.sv | 37 +++
 rtl/tl_debounce.sv | 73 +++++++
 rtl/taillights_input_cond.sv | 109 ++++++++++
 4 files changed

// File: rtl/taillights_pkg.sv
// ---------------------------------------------------------------------------
// taillights_pkg
// Shared types and default constants for the taillights controller.
//   req_t              prioritized turn request handed to the sequencing FSM
//   TICK_DIV_DEFAULT   clk cycles per blink step (4 Hz at 100 MHz)
//   DB_CYCLES_DEFAULT  cycles a synced switch must hold a new level before
//                      it is accepted
// ---------------------------------------------------------------------------
package taillights_pkg;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_HAZ   = 2'd3
  } req_t;

  localparam int TICK_DIV_DEFAULT  = 25_000_000;
  localparam int DB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/taillights_input_cond_if.sv
// ---------------------------------------------------------------------------
// taillights_input_cond_if
// Bundles the raw switch inputs and the conditioned outputs of the taillights
// input conditioner.
//   left_in/right_in/haz_in  raw switches, asynchronous to clk
//   req                      registered prioritized request (req_t)
//   tick                     one-cycle blink-step strobe
// Modports:
//   master  drives the switches and observes req/tick (board side / bench)
//   slave   the conditioner itself
// ---------------------------------------------------------------------------
interface taillights_input_cond_if;
  import taillights_pkg::*;

  logic left_in;
  logic right_in;
  logic haz_in;
  req_t req;
  logic tick;

  modport master (
    output left_in,
    output right_in,
    output haz_in,
    input  req,
    input  tick
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  haz_in,
    output req,
    output tick
  );

endinterface

// File: rtl/tl_debounce.sv
// ---------------------------------------------------------------------------
// tl_debounce
// One switch channel: two-flop synchronizer followed by an optional
// debounce counter.
//   clk    in  system clock, rising edge
//   rst    in  synchronous, active-high reset
//   raw    in  raw switch level, asynchronous to clk
//   level  out accepted (stable) switch level
// Configuration macro: TAILLIGHTS_DEBOUNCE_EN
//   defined   -> a new synced level must persist DB_CYCLES consecutive cycles
//   undefined -> level follows the synchronizer output directly
// ---------------------------------------------------------------------------
module tl_debounce #(
  parameter int DB_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("tl_debounce: DB_CYCLES must be >= 1");
  end

  logic sync1;
  logic sync2;

  // Two-flop synchronizer; the raw switch is asynchronous, so sync1 may go
  // metastable and only sync2 is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef TAILLIGHTS_DEBOUNCE_EN
  // A width of at least 1 keeps DB_CYCLES == 1 legal.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          stable;

  // Count consecutive cycles in which the synced level disagrees with the
  // accepted one. Any cycle of agreement (a bounce) clears the count, so
  // only an uninterrupted run of DB_CYCLES cycles flips the stable level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 != stable) begin
      if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign level = stable;
`else
  assign level = sync2;
`endif

endmodule

// File: rtl/taillights_input_cond.sv
// ---------------------------------------------------------------------------
// taillights_input_cond
// Front end of the taillights controller: conditions the three raw switches,
// encodes them into one prioritized request and generates the blink-step tick
// that advances the sequencing FSM.
//   clk   in  system clock, rising edge
//   rst   in  synchronous, active-high reset
//   bus   taillights_input_cond_if.slave
//         left_in/right_in/haz_in in, req (req_t) out, tick out
// Parameters:
//   TICK_DIV   clk cycles per blink step, >= 2
//   DB_CYCLES  debounce length in cycles, >= 1
// Configuration macro: TAILLIGHTS_DEBOUNCE_EN (see tl_debounce)
// ---------------------------------------------------------------------------
module taillights_input_cond
  import taillights_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input logic                          clk,
  input logic                          rst,
  taillights_input_cond_if.slave       bus
);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("taillights_input_cond: TICK_DIV must be >= 2");
  end

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic          left_s;
  logic          right_s;
  logic          haz_s;
  req_t          next_req;
  req_t          req_q;
  logic          restart;
  logic [TW-1:0] tick_cnt;
  logic          tick_q;

  tl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.left_in),
    .level (left_s)
  );

  tl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.right_in),
    .level (right_s)
  );

  tl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_haz (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.haz_in),
    .level (haz_s)
  );

  // Priority encode: hazard wins, and both turn switches together are also
  // treated as a hazard request.
  always_comb begin
    next_req = REQ_NONE;
    if (haz_s || (left_s && right_s)) begin
      next_req = REQ_HAZ;
    end else if (left_s) begin
      next_req = REQ_LEFT;
    end else if (right_s) begin
      next_req = REQ_RIGHT;
    end
  end

  assign restart = (next_req != req_q);

  // Request register; the FSM sees a clean, glitch-free request.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= REQ_NONE;
    end else begin
      req_q <= next_req;
    end
  end

  // Blink-step divider. A change of request reloads the phase so the FSM
  // gets a full first step for the new pattern; that reload takes priority
  // over a coinciding wrap, suppressing the tick for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (restart) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (tick_cnt == TICK_MAX) begin
      tick_cnt <= '0;
      tick_q   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick_q   <= 1'b0;
    end
  end

  assign bus.req  = req_q;
  assign bus.tick = tick_q;

endmodule
